mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM boundary and the write-back stage.
- Owns the data memory: a synchronous single-port RAM.
- Executes loads and stores.
- Registers {OP, DR, wb_data} into the MEM/WB boundary, where write-back consumes them unchanged.
- Loads take one extra cycle; STALL back-pressures upstream while a load completes.

Parameters:
ADDR_W, 8, data memory address width; depth = 2**ADDR_W words
DATA_W, 16, data word width; must match wb_data width of write-back (16)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  EX result present this cycle
IN_OP  in  2  instruction class; bit0 = register write requested
IN_DR  in  3  destination register
IN_MEMOP  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
IN_ALU  in  DATA_W  ALU result; also the memory address (low ADDR_W bits)
IN_STDATA  in  DATA_W  store data
STALL  out  1  upstream must hold all IN_* stable while high
OUT_VALID  out  1  MEM/WB register holds a real instruction
OP  out  2  to write-back; 00 on bubble
DR  out  3  to write-back
wb_data  out  DATA_W  to write-back

Behaviour:
- Reset (RST=1, async, any state):
  - OUT_VALID=0, OP=00, DR=000, wb_data=0, STALL=0, FSM=RUN.
  - RAM contents are not reset.
  - A load in flight is discarded with no output.
- Address: IN_ALU[ADDR_W-1:0]; upper bits ignored; no out-of-range condition.
- FSM, two states: RUN and LOAD.
- RUN, instruction accepted when IN_VALID=1 and STALL=0:
  - MEMOP none/reserved:
    - next edge: OUT_VALID=1, OP=IN_OP, DR=IN_DR, wb_data=IN_ALU.
    - Latency 1.
  - MEMOP store:
    - RAM[addr] written at the accepting edge.
    - next edge: OUT_VALID=1, OP={IN_OP[1],1'b0} (write-back forced off), DR=IN_DR, wb_data=IN_STDATA.
  - MEMOP load:
    - RAM read issued at the accepting edge; OP/DR latched into hold registers.
    - FSM→LOAD; STALL=1 for exactly the LOAD cycle (combinational from state).
    - MEM/WB register is loaded with a bubble at that edge: OUT_VALID=0, OP=00.
  - IN_VALID=0: next edge loads a bubble (OUT_VALID=0, OP=00, DR and wb_data hold previous values).
- LOAD:
  - IN_* ignored.
  - next edge: OUT_VALID=1, OP=held OP, DR=held DR, wb_data=RAM read data; FSM→RUN; STALL drops.
  - Load latency from acceptance to OUT_VALID: 2 edges.
- Back-to-back loads: one result per 2 cycles; the second load is accepted in the cycle after LOAD.
- Store then load to the same address in consecutive cycles: the load returns the new data. A RAM write at edge N is visible to a read at edge N+1.
- Nothing passes through to the outputs combinationally except STALL.
- Only one memory operation per cycle, so the RAM never sees a simultaneous read and write.

Decomposition:
- Shared package pipe_pkg holds:
  - MEMOP_NONE/LOAD/STORE encodings.
  - OP_WB_BIT=0.
  - Register-index width (3) and DATA_W (16).
- One sub-module, data_ram: synchronous RAM with 1 write port, registered read data, parameterised by ADDR_W/DATA_W, no reset.

Test Plan:
1. Reset mid-operation: assert RST async while FSM=LOAD → outputs immediately OUT_VALID=0, OP=00, DR=0, wb_data=0, STALL=0; no result appears after release.
2. ALU pass-through: IN_OP=01, IN_DR=5, IN_ALU=16'h1234, MEMOP=none → one edge later OUT_VALID=1, OP=01, DR=5, wb_data=16'h1234.
3. Store then load: store IN_ALU=16'h0010, IN_STDATA=16'hBEEF, IN_OP=01, then immediately load from 16'h0010 with IN_DR=3:
   - Store response: OP=00, wb_data=16'hBEEF.
   - Load response: STALL high for 1 cycle; two edges after load acceptance OUT_VALID=1, OP=01, DR=3, wb_data=16'hBEEF.
4. Address aliasing: store 16'h00AA to IN_ALU=16'hFF05, load from 16'h0005 → wb_data=16'h00AA.
5. Back-to-back loads from 0x20 and 0x21 (preloaded 16'h1111, 16'h2222) with the upstream honouring STALL:
   - Results on cycles 2 and 4 with data 16'h1111 and 16'h2222.
   - Bubbles (OP=00) on cycles 1 and 3.
   - Second load inputs ignored during STALL.
6. Bubble insertion: IN_VALID=0 for 3 cycles → OUT_VALID=0 and OP=00 each cycle; DR/wb_data hold; no RAM write.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-operation encodings, write-back flag
// position, register-index and data widths, and the MEM stage FSM states.
package pipe_pkg;

   localparam logic [1:0] MEMOP_NONE  = 2'b00;
   localparam logic [1:0] MEMOP_LOAD  = 2'b01;
   localparam logic [1:0] MEMOP_STORE = 2'b10;

   localparam int OP_WB_BIT   = 0;
   localparam int REG_W       = 3;
   localparam int PIPE_DATA_W = 16;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM input bundle plus MEM/WB output bundle of the MEM stage.
// master = upstream/write-back side, slave = the MEM stage itself.
interface mem_stage_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W
);
   logic              IN_VALID;
   logic [1:0]        IN_OP;
   logic [REG_W-1:0]  IN_DR;
   logic [1:0]        IN_MEMOP;
   logic [DATA_W-1:0] IN_ALU;
   logic [DATA_W-1:0] IN_STDATA;
   logic              STALL;
   logic              OUT_VALID;
   logic [1:0]        OP;
   logic [REG_W-1:0]  DR;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output IN_VALID, IN_OP, IN_DR, IN_MEMOP, IN_ALU, IN_STDATA,
      input  STALL, OUT_VALID, OP, DR, wb_data
   );

   modport slave (
      input  IN_VALID, IN_OP, IN_DR, IN_MEMOP, IN_ALU, IN_STDATA,
      output STALL, OUT_VALID, OP, DR, wb_data
   );
endinterface

// File: rtl/data_ram.sv
// Synchronous single-port data memory: one write port, registered read data.
// Contents are deliberately not reset.
module data_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Write on we, capture read data on re; the stage never asserts both.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: executes loads/stores against the data RAM and
// registers {OP, DR, wb_data} into the MEM/WB boundary. Loads spend one
// extra cycle in LOAD while STALL holds upstream.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input logic        CLK,
   input logic        RST,
   mem_stage_if.slave bus
);
   mem_state_e        state_q, state_d;
   logic              valid_q, valid_d;
   logic [1:0]        op_q, op_d;
   logic [REG_W-1:0]  dr_q, dr_d;
   logic [DATA_W-1:0] wb_q, wb_d;
   logic [1:0]        hold_op_q, hold_op_d;
   logic [REG_W-1:0]  hold_dr_q, hold_dr_d;
   logic              ram_we_s, ram_re_s;
   logic [DATA_W-1:0] ram_rdata_s;

   data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (CLK),
      .we    (ram_we_s),
      .re    (ram_re_s),
      .addr  (bus.IN_ALU[ADDR_W-1:0]),
      .wdata (bus.IN_STDATA),
      .rdata (ram_rdata_s)
   );

   // Next-state, MEM/WB register contents and RAM strobes.
   always_comb begin
      state_d   = state_q;
      valid_d   = 1'b0;
      op_d      = 2'b00;
      dr_d      = dr_q;
      wb_d      = wb_q;
      hold_op_d = hold_op_q;
      hold_dr_d = hold_dr_q;
      ram_we_s  = 1'b0;
      ram_re_s  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.IN_VALID) begin
               case (bus.IN_MEMOP)
                  MEMOP_LOAD: begin
                     // Bubble now; the result leaves from LOAD next edge.
                     ram_re_s  = 1'b1;
                     hold_op_d = bus.IN_OP;
                     hold_dr_d = bus.IN_DR;
                     state_d   = ST_LOAD;
                  end
                  MEMOP_STORE: begin
                     ram_we_s         = 1'b1;
                     valid_d          = 1'b1;
                     op_d             = bus.IN_OP;
                     op_d[OP_WB_BIT]  = 1'b0;
                     dr_d             = bus.IN_DR;
                     wb_d             = bus.IN_STDATA;
                  end
                  default: begin
                     // Plain ALU result (reserved encoding behaves the same).
                     valid_d = 1'b1;
                     op_d    = bus.IN_OP;
                     dr_d    = bus.IN_DR;
                     wb_d    = bus.IN_ALU;
                  end
               endcase
            end else begin
               valid_d = 1'b0;
            end
         end
         ST_LOAD: begin
            valid_d = 1'b1;
            op_d    = hold_op_q;
            dr_d    = hold_dr_q;
            wb_d    = ram_rdata_s;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and MEM/WB registers; a reset also drops any load in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_RUN;
         valid_q   <= 1'b0;
         op_q      <= 2'b00;
         dr_q      <= {REG_W{1'b0}};
         wb_q      <= {DATA_W{1'b0}};
         hold_op_q <= 2'b00;
         hold_dr_q <= {REG_W{1'b0}};
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         op_q      <= op_d;
         dr_q      <= dr_d;
         wb_q      <= wb_d;
         hold_op_q <= hold_op_d;
         hold_dr_q <= hold_dr_d;
      end
   end

   assign bus.STALL     = (state_q == ST_LOAD);
   assign bus.OUT_VALID = valid_q;
   assign bus.OP        = op_q;
   assign bus.DR        = dr_q;
   assign bus.wb_data   = wb_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised plus directed bench for mem_stage against a transaction-level
// model: a plain memory array and a "load pending" record.
module tb_mem_stage;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_stage_if #(.DATA_W(16)) bus ();

   mem_stage #(.ADDR_W(8), .DATA_W(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // reference model
   logic [15:0] m_mem [256];
   bit          m_pend;
   logic [1:0]  m_hop;
   logic [2:0]  m_hdr;
   logic [7:0]  m_haddr;
   logic        m_ov;
   logic [1:0]  m_op;
   logic [2:0]  m_dr;
   logic [15:0] m_wb;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_pend = 1'b0;
      m_ov = 1'b0; m_op = 2'b00; m_dr = 3'd0; m_wb = 16'h0000;
   endtask

   // One clock edge of behaviour, from the inputs presented before it.
   task automatic model_step(input logic v, input logic [1:0] op, input logic [2:0] dr,
                             input logic [1:0] mo, input logic [15:0] alu, input logic [15:0] st);
      if (m_pend) begin
         m_pend = 1'b0;
         m_ov = 1'b1; m_op = m_hop; m_dr = m_hdr; m_wb = m_mem[m_haddr];
      end else if (!v) begin
         m_ov = 1'b0; m_op = 2'b00;
      end else if (mo == 2'b01) begin
         m_pend = 1'b1; m_hop = op; m_hdr = dr; m_haddr = alu[7:0];
         m_ov = 1'b0; m_op = 2'b00;
      end else if (mo == 2'b10) begin
         m_mem[alu[7:0]] = st;
         m_ov = 1'b1; m_op = op & 2'b10; m_dr = dr; m_wb = st;
      end else begin
         m_ov = 1'b1; m_op = op; m_dr = dr; m_wb = alu;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".valid"}, {31'd0, bus.OUT_VALID}, {31'd0, m_ov});
      check_eq({tag, ".op"},    {30'd0, bus.OP},        {30'd0, m_op});
      check_eq({tag, ".dr"},    {29'd0, bus.DR},        {29'd0, m_dr});
      check_eq({tag, ".wb"},    {16'd0, bus.wb_data},   {16'd0, m_wb});
   endtask

   // Called just after a falling edge: drive, check STALL, clock, check.
   task automatic cyc(input string tag, input logic v, input logic [1:0] op, input logic [2:0] dr,
                      input logic [1:0] mo, input logic [15:0] alu, input logic [15:0] st);
      bus.IN_VALID = v; bus.IN_OP = op; bus.IN_DR = dr;
      bus.IN_MEMOP = mo; bus.IN_ALU = alu; bus.IN_STDATA = st;
      #1;
      check_eq({tag, ".stall"}, {31'd0, bus.STALL}, {31'd0, m_pend});
      @(posedge CLK);
      model_step(v, op, dr, mo, alu, st);
      @(negedge CLK);
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 1'b0, 2'($urandom), 3'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
   endtask

   initial begin
      model_reset();
      bus.IN_VALID = 1'b0; bus.IN_OP = 2'b00; bus.IN_DR = 3'd0;
      bus.IN_MEMOP = 2'b00; bus.IN_ALU = 16'h0000; bus.IN_STDATA = 16'h0000;
      repeat (2) @(negedge CLK);
      check_outputs("reset");
      check_eq("reset.stall", {31'd0, bus.STALL}, 32'd0);
      RST = 1'b0;

      // fill the whole memory so every later load has a known value
      for (int a = 0; a < 256; a++)
         cyc("fill", 1'b1, 2'($urandom), 3'($urandom), 2'b10, {8'($urandom), 8'(a)}, 16'($urandom));

      // ALU pass-through
      cyc("alu", 1'b1, 2'b01, 3'd5, 2'b00, 16'h1234, 16'h0000);
      check_eq("alu.wb_const", {16'd0, bus.wb_data}, 32'h0000_1234);

      // store then load, same address
      cyc("st", 1'b1, 2'b01, 3'd1, 2'b10, 16'h0010, 16'hBEEF);
      check_eq("st.op_const", {30'd0, bus.OP}, 32'd0);
      cyc("ld", 1'b1, 2'b01, 3'd3, 2'b01, 16'h0010, 16'h0000);
      cyc("ld.wait", 1'b1, 2'b01, 3'd3, 2'b01, 16'h0010, 16'h0000);
      check_eq("ld.wb_const", {16'd0, bus.wb_data}, 32'h0000_BEEF);
      check_eq("ld.dr_const", {29'd0, bus.DR}, 32'd3);

      // address aliasing through ignored upper bits
      cyc("alias.st", 1'b1, 2'b00, 3'd2, 2'b10, 16'hFF05, 16'h00AA);
      cyc("alias.ld", 1'b1, 2'b01, 3'd4, 2'b01, 16'h0005, 16'h0000);
      idle("alias.wait");
      check_eq("alias.wb_const", {16'd0, bus.wb_data}, 32'h0000_00AA);

      // back-to-back loads, junk inputs while stalled
      cyc("b2b.p0", 1'b1, 2'b01, 3'd0, 2'b10, 16'h0020, 16'h1111);
      cyc("b2b.p1", 1'b1, 2'b01, 3'd0, 2'b10, 16'h0021, 16'h2222);
      cyc("b2b.c1", 1'b1, 2'b01, 3'd6, 2'b01, 16'h0020, 16'h0000);
      cyc("b2b.c2", 1'b1, 2'b11, 3'd7, 2'b10, 16'h0022, 16'hDEAD);
      check_eq("b2b.d1", {16'd0, bus.wb_data}, 32'h0000_1111);
      cyc("b2b.c3", 1'b1, 2'b01, 3'd7, 2'b01, 16'h0021, 16'h0000);
      cyc("b2b.c4", 1'b1, 2'b01, 3'd2, 2'b10, 16'h0021, 16'hBAD0);
      check_eq("b2b.d2", {16'd0, bus.wb_data}, 32'h0000_2222);

      // bubble insertion
      for (int i = 0; i < 3; i++) idle("bubble");
      cyc("bubble.rd", 1'b1, 2'b01, 3'd1, 2'b01, 16'h0022, 16'h0000);
      idle("bubble.rdw");
      check_eq("bubble.nowr", {16'd0, bus.wb_data}, {16'd0, m_mem[8'h22]});

      // reset while in LOAD
      bus.IN_VALID = 1'b1; bus.IN_OP = 2'b01; bus.IN_DR = 3'd5;
      bus.IN_MEMOP = 2'b01; bus.IN_ALU = 16'h0030; bus.IN_STDATA = 16'h0000;
      @(posedge CLK);
      model_step(1'b1, 2'b01, 3'd5, 2'b01, 16'h0030, 16'h0000);
      #2 RST = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_mid");
      check_eq("rst_mid.stall", {31'd0, bus.STALL}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 3; i++) idle("rst_after");

      // random traffic, IN_* randomised even while stalled
      for (int i = 0; i < 400; i++)
         cyc("rand", 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
             16'($urandom), 16'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
